inst_fetch_queue: RTL and testbench

- Fetch-side stage directly upstream of the pipeline's IF/ID register.
- Generates sequential instruction addresses, handshakes with instruction memory, and buffers fetched {pc, inst} pairs in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake; decode drops ready on a stall.
- On a taken branch (redirect), flushes all buffered and in-flight instructions and restarts fetch at the target.

---
 rtl/inst_fetch_pkg.sv | 29 ++
 rtl/inst_fetch_queue_fifo.sv | 53 +++++
 rtl/inst_fetch_queue.sv | 123 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package inst_fetch_pkg;

   localparam int unsigned PC_WIDTH_DEF   = 5;
   localparam int unsigned INST_WIDTH_DEF = 32;
   localparam int unsigned DEPTH_DEF      = 4;

   // DRAIN waits out a request that was orphaned by a redirect
   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_WIDTH_DEF-1:0]   pc;
      logic [INST_WIDTH_DEF-1:0] inst;
   } fetch_entry_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] a, input logic inc);
      return (inc && (a != 16'hFFFF)) ? a + 16'd1 : a;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush and an occupancy count.
// Storage is not reset; only pointers and count are.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 37
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   // Pointer and occupancy tracking; flush empties the queue in one edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage write
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch address generation, single-outstanding
// memory handshake, {pc, inst} buffering and redirect flush.
// Optional FETCH_PERF_EN adds saturating fetched/discarded counters.
module inst_fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
   parameter int unsigned INST_WIDTH = INST_WIDTH_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         mem_req,
   output logic [PC_WIDTH-1:0]          mem_addr,
   input  logic                         mem_ack,
   input  logic [INST_WIDTH-1:0]        mem_inst,
   input  logic                         redirect,
   input  logic [PC_WIDTH-1:0]          redirect_pc,
   output logic                         deq_valid,
   input  logic                         deq_ready,
   output logic [INST_WIDTH-1:0]        deq_inst,
   output logic [PC_WIDTH-1:0]          deq_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]                  perf_fetched,
   output logic [7:0]                   perf_discarded
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned ENT_W = PC_WIDTH + INST_WIDTH;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   fetch_state_t          state_q;
   logic [PC_WIDTH-1:0]   fetch_pc_q, req_addr_q, hold_pc_q;
   logic [INST_WIDTH-1:0] hold_inst_q;
   logic                  outstanding_q;
   logic                  push, pop;
   logic [ENT_W-1:0]      head;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata ({mem_addr, mem_inst}),
      .rdata (head),
      .count (count)
   );

   // Request generation; an outstanding request is held until acked, even across redirects
   always_comb begin
      mem_req   = ~rst & (outstanding_q |
                  ((state_q == FETCH) & ~redirect & (count < FULL_COUNT)));
      mem_addr  = outstanding_q ? req_addr_q : fetch_pc_q;
      push      = (state_q == FETCH) & mem_req & mem_ack & ~redirect;
      deq_valid = (count != '0) & ~redirect;
      pop       = deq_valid & deq_ready;
      deq_pc    = deq_valid ? head[ENT_W-1:INST_WIDTH] : hold_pc_q;
      deq_inst  = deq_valid ? head[INST_WIDTH-1:0]     : hold_inst_q;
   end

   // Fetch PC, outstanding-request tracking and FETCH/DRAIN sequencing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FETCH;
         fetch_pc_q    <= '0;
         req_addr_q    <= '0;
         outstanding_q <= 1'b0;
      end else begin
         outstanding_q <= mem_req & ~mem_ack;
         if (mem_req && !outstanding_q) req_addr_q <= fetch_pc_q;
         if (redirect)  fetch_pc_q <= redirect_pc;
         else if (push) fetch_pc_q <= fetch_pc_q + PC_WIDTH'(1);
         case (state_q)
            FETCH:   if (redirect && outstanding_q && !mem_ack) state_q <= DRAIN;
            DRAIN:   if (mem_ack) state_q <= FETCH;
            default: state_q <= FETCH;
         endcase
      end
   end

   // Keep the last presented head stable while nothing is valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_pc_q   <= '0;
         hold_inst_q <= '0;
      end else if (deq_valid) begin
         hold_pc_q   <= head[ENT_W-1:INST_WIDTH];
         hold_inst_q <= head[INST_WIDTH-1:0];
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_q;
   logic [7:0]  perf_discarded_q;
   logic        resp_dropped;
   logic [7:0]  discard_inc;

   assign resp_dropped = mem_req & mem_ack & (redirect | (state_q == DRAIN));
   assign discard_inc  = (redirect ? 8'(count) : 8'd0) + {7'd0, resp_dropped};

   // Saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_discarded_q <= '0;
      end else begin
         perf_fetched_q   <= sat_inc16(perf_fetched_q, push);
         perf_discarded_q <= sat_add8(perf_discarded_q, discard_inc);
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a configurable-latency memory model.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_ack;
   logic [4:0]  mem_addr;
   logic [31:0] mem_inst;
   logic        redirect;
   logic [4:0]  redirect_pc;
   logic        deq_valid, deq_ready;
   logic [31:0] deq_inst;
   logic [4:0]  deq_pc;
   logic [2:0]  count;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched;
   logic [7:0]  perf_discarded;
`endif

   logic [3:0]  lat;
   logic [3:0]  wait_q;
   int          checks = 0;
   int          fails  = 0;
   logic        found;

   inst_fetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_inst    (mem_inst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .deq_valid   (deq_valid),
      .deq_ready   (deq_ready),
      .deq_inst    (deq_inst),
      .deq_pc      (deq_pc),
      .count       (count)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_discarded (perf_discarded)
`endif
   );

   always #5 clk = ~clk;

   // Memory: ack after 'lat' cycles of a held request; data = 0x100 + address
   assign mem_ack  = mem_req && (wait_q == lat);
   assign mem_inst = 32'h100 + 32'(mem_addr);

   always @(posedge clk or posedge rst) begin
      if (rst)                     wait_q <= '0;
      else if (mem_req && !mem_ack) wait_q <= wait_q + 4'd1;
      else                         wait_q <= '0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic reset_dut(input logic [3:0] lat_v, input logic ready_v);
      lat         = lat_v;
      deq_ready   = ready_v;
      redirect    = 1'b0;
      redirect_pc = '0;
      rst         = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_addr(input logic [4:0] a, input logic need_ack);
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (mem_req && (mem_addr == a) && (!need_ack || mem_ack)) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("wait_addr_reached", found, 1);
   endtask

   initial begin
      // Reset values
      lat = 0; deq_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      rst = 1'b1;
      #2;
      check("rst_mem_req", mem_req, 0);
      check("rst_deq_valid", deq_valid, 0);
      check("rst_count", count, 0);
      check("rst_deq_pc", deq_pc, 0);
      check("rst_deq_inst", deq_inst, 0);

      // Zero-wait streaming: one instruction per cycle
      reset_dut(4'd0, 1'b1);
      check("s1_mem_req", mem_req, 1);
      check("s1_mem_addr", mem_addr, 0);
      check("s1_no_bypass", deq_valid, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("s1_valid", deq_valid, 1);
         check("s1_pc", deq_pc, i);
         check("s1_inst", deq_inst, 32'h100 + i);
         check("s1_count", count, 1);
      end

      // Stall fills the queue, release drains in order
      reset_dut(4'd0, 1'b0);
      repeat (10) tick();
      check("s2_full_count", count, 4);
      check("s2_no_req", mem_req, 0);
      check("s2_fetch_pc", mem_addr, 4);
      check("s2_head_pc", deq_pc, 0);
      deq_ready = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         check("s2_valid", deq_valid, 1);
         check("s2_pc", deq_pc, i);
         tick();
      end

      // Redirect during an un-acked request enters DRAIN
      reset_dut(4'd3, 1'b0);
      wait_addr(5'd2, 1'b0);
      check("s3_count_before", count, 2);
      tick();
      redirect = 1'b1; redirect_pc = 5'd12;
      #1;
      check("s3_req_held", mem_req, 1);
      check("s3_addr_held", mem_addr, 2);
      check("s3_no_ack", mem_ack, 0);
      check("s3_valid_forced", deq_valid, 0);
      tick();
      redirect = 1'b0;
      #1;
      check("s3_flushed", count, 0);
      check("s3_drain_req", mem_req, 1);
      check("s3_drain_addr", mem_addr, 2);
      tick();
      check("s3_stale_ack", mem_ack, 1);
      check("s3_stale_addr", mem_addr, 2);
      tick();
      check("s3_new_req", mem_req, 1);
      check("s3_new_addr", mem_addr, 12);
      check("s3_stale_dropped", count, 0);
      deq_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (deq_valid) begin found = 1'b1; break; end
         tick();
      end
      check("s3_deq_seen", found, 1);
      check("s3_first_pc", deq_pc, 12);
      check("s3_first_inst", deq_inst, 32'h10C);

      // Redirect coinciding with the ack of address 5, count 3: no DRAIN
      reset_dut(4'd1, 1'b0);
      redirect = 1'b1; redirect_pc = 5'd2;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      wait_addr(5'd5, 1'b1);
      check("s4_count_before", count, 3);
      check("s4_valid_before", deq_valid, 1);
      redirect = 1'b1; redirect_pc = 5'd20;
      #1;
      check("s4_valid_forced", deq_valid, 0);
      check("s4_req", mem_req, 1);
      check("s4_ack", mem_ack, 1);
      tick();
      redirect = 1'b0;
      #1;
      check("s4_flushed", count, 0);
      check("s4_new_addr", mem_addr, 20);
      check("s4_new_req", mem_req, 1);
      check("s4_empty", deq_valid, 0);
      tick();
      check("s4_ack_20", mem_ack, 1);
      check("s4_addr_20", mem_addr, 20);

      // PC wrap 31 -> 0
      reset_dut(4'd0, 1'b1);
      redirect = 1'b1; redirect_pc = 5'd30;
      #1;
      check("s5_redirect_no_req", mem_req, 0);
      tick();
      redirect = 1'b0;
      #1;
      check("s5_addr30", mem_addr, 30);
      tick();
      check("s5_pc30", deq_pc, 30);
      check("s5_addr31", mem_addr, 31);
      tick();
      check("s5_pc31", deq_pc, 31);
      check("s5_addr_wrap", mem_addr, 0);
      tick();
      check("s5_pc0", deq_pc, 0);
      check("s5_inst0", deq_inst, 32'h100);
      tick();
      check("s5_pc1", deq_pc, 1);

      // Asynchronous reset in the middle of DRAIN
      reset_dut(4'd3, 1'b0);
      wait_addr(5'd2, 1'b0);
      tick();
      redirect = 1'b1; redirect_pc = 5'd12;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      check("s6_drain_addr", mem_addr, 2);
      check("s6_hold_inst", deq_inst, 32'h100);
`ifdef FETCH_PERF_EN
      check("s6_perf_fetched", perf_fetched, 2);
      check("s6_perf_discarded", perf_discarded, 2);
`endif
      rst = 1'b1;
      #1;
      check("s6_rst_req", mem_req, 0);
      check("s6_rst_count", count, 0);
      check("s6_rst_valid", deq_valid, 0);
      check("s6_rst_inst", deq_inst, 0);
      check("s6_rst_pc", deq_pc, 0);
`ifdef FETCH_PERF_EN
      check("s6_rst_perf_fetched", perf_fetched, 0);
      check("s6_rst_perf_discarded", perf_discarded, 0);
`endif
      lat = 4'd0; deq_ready = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("s6_restart_req", mem_req, 1);
      check("s6_restart_addr", mem_addr, 0);
      tick();
      check("s6_restart_valid", deq_valid, 1);
      check("s6_restart_pc", deq_pc, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
